// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 scancode receiver
package ps2_pkg;
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int PS2_EVENT_W = 10;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO, head word held in storage, push accepted when full if a pop coincides
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic wr, rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign dout  = empty ? '0 : mem[rd_ptr];
    // storage array, written without reset
    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= din;
    // pointers and occupancy
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
endmodule

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver: oversampled PS/2 receiver folding E0/F0 prefixes into key events behind a FIFO
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       frame_err,
    output logic       overflow
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic [FW-1:0] clk_cnt, data_cnt;
    logic [TW-1:0] tmo;
    logic filt_clk, filt_data, filt_clk_q, strobe;
    ps2_state_e state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic par_bit, byte_valid, ext, brk, push, pop, fifo_full, fifo_empty;
    logic [PS2_EVENT_W-1:0] head;
    assign strobe = filt_clk_q & ~filt_clk;
    // bring both raw lines into the clk domain
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    // a filtered line flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            filt_clk   <= 1'b1;
            filt_data  <= 1'b1;
            filt_clk_q <= 1'b1;
            clk_cnt    <= '0;
            data_cnt   <= '0;
        end else begin
            filt_clk_q <= filt_clk;
            if (clk_sync[SYNC_STAGES-1] == filt_clk) clk_cnt <= '0;
            else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[SYNC_STAGES-1];
                clk_cnt  <= '0;
            end else clk_cnt <= clk_cnt + FW'(1);
            if (data_sync[SYNC_STAGES-1] == filt_data) data_cnt <= '0;
            else if (data_cnt == FW'(FILTER_LEN - 1)) begin
                filt_data <= data_sync[SYNC_STAGES-1];
                data_cnt  <= '0;
            end else data_cnt <= data_cnt + FW'(1);
        end
    // frame FSM: start, 8 data bits LSB first, odd parity, stop, with inter-edge timeout
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tmo        <= '0;
            frame_err  <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            byte_valid <= 1'b0;
            tmo <= (state == IDLE || strobe) ? '0 : tmo + TW'(1);
            if (state != IDLE && !strobe && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end else if (strobe)
                case (state)
                    IDLE:
                        if (filt_data) frame_err <= 1'b1;
                        else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    DATA: begin
                        shreg   <= {filt_data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= filt_data;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (filt_data && ^{shreg, par_bit}) byte_valid <= 1'b1;
                        else frame_err <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end
    assign push = byte_valid && shreg != PS2_PREFIX_EXT && shreg != PS2_PREFIX_BRK;
    // prefix flags accumulate until a plain byte or any frame error
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid) begin
            ext <= (shreg == PS2_PREFIX_EXT) | (ext & (shreg == PS2_PREFIX_BRK));
            brk <= (shreg == PS2_PREFIX_BRK) | (brk & (shreg == PS2_PREFIX_EXT));
        end
    // a push that finds the FIFO full with no pop is lost
    always_ff @(posedge clk or posedge rst)
        if (rst) overflow <= 1'b0;
        else overflow <= push & fifo_full & ~pop;
    assign pop      = ev_valid & ev_ready;
    assign ev_valid = ~fifo_empty;
    assign {ev_ext, ev_break, ev_code} = head;
    ps2_event_fifo #(.WIDTH(PS2_EVENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({ext, brk, shreg}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb_ps2_scancode_receiver: directed PS/2 frames with hand-computed expected events
module tb_ps2_scancode_receiver;
    localparam int FL = 8;
    localparam int TO = 2000;
    localparam int H  = 40;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, ev_ready = 1'b0;
    logic ev_valid, ev_break, ev_ext, frame_err, overflow;
    logic [7:0] ev_code;
    int checks = 0, errors = 0, n_err = 0, n_ovf = 0, rd = 0;
    logic [9:0] evs [$];
    always #5 clk = ~clk;
    ps2_scancode_receiver #(.SYNC_STAGES(2), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_break(ev_break),
        .ev_ext(ev_ext), .frame_err(frame_err), .overflow(overflow)
    );
    always @(negedge clk)
        if (!rst) begin
            if (ev_valid && ev_ready) evs.push_back({ev_ext, ev_break, ev_code});
            if (frame_err) n_err++;
            if (overflow) n_ovf++;
        end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic ps2_bit(input logic b, input logic glitch);
        ps2_data = b;
        if (glitch) begin
            cyc(10);
            ps2_clk = 1'b0;
            cyc(FL - 1);
            ps2_clk = 1'b1;
            cyc(H - 10 - (FL - 1));
        end else cyc(H);
        ps2_clk = 1'b0;
        cyc(H);
        ps2_clk = 1'b1;
    endtask
    task automatic send(input logic [7:0] b, input logic bad_par = 1'b0, input int nbits = 11, input logic glitch = 1'b0);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch && i == 3);
        ps2_data = 1'b1;
        cyc(2 * H);
    endtask
    task automatic expect_ev(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        got = (rd < evs.size()) ? evs[rd] : 10'h3FF;
        check(tag, got, exp);
        rd++;
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, ev_valid, 0);
        check({tag, "_code"}, ev_code, 0);
        check({tag, "_flags"}, {ev_break, ev_ext, frame_err, overflow}, 0);
    endtask
    initial begin
        cyc(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        ev_ready = 1'b1;
        cyc(30);
        send(8'h1C);
        expect_ev("make_1c", 10'h01C);
        check("make_err", n_err, 0);
        send(8'hF0);
        send(8'h1C);
        expect_ev("break_1c", 10'h11C);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        expect_ev("ext_break_75", 10'h375);
        check("prefix_count", evs.size(), 3);
        send(8'h1C, 1'b1);
        check("parity_err", n_err, 1);
        check("parity_noev", evs.size(), 3);
        send(8'h32);
        expect_ev("after_parity_32", 10'h032);
        send(8'hE0);
        send(8'h55, 1'b0, 5);
        cyc(TO);
        check("timeout_err", n_err, 2);
        send(8'h1C);
        expect_ev("after_timeout_1c", 10'h01C);
        ev_ready = 1'b0;
        send(8'h15);
        send(8'h1D);
        send(8'h24);
        send(8'h2D);
        check("no_ovf_at_4", n_ovf, 0);
        send(8'h2C);
        check("ovf_pulse", n_ovf, 1);
        check("hold_valid", ev_valid, 1);
        check("hold_code", ev_code, 8'h15);
        ev_ready = 1'b1;
        cyc(10);
        expect_ev("pop0", 10'h015);
        expect_ev("pop1", 10'h01D);
        expect_ev("pop2", 10'h024);
        expect_ev("pop3", 10'h02D);
        check("drained", ev_valid, 0);
        check("pop_count", evs.size(), 9);
        send(8'h4D, 1'b0, 11, 1'b1);
        expect_ev("glitch_4d", 10'h04D);
        ev_ready = 1'b0;
        send(8'h1B);
        check("pre_rst_valid", ev_valid, 1);
        send(8'hE0);
        send(8'h6B, 1'b0, 5);
        rst = 1'b1;
        cyc(3);
        check_idle_outputs("midrst");
        rst = 1'b0;
        cyc(5);
        check("post_rst_valid", ev_valid, 0);
        ev_ready = 1'b1;
        send(8'h2C);
        expect_ev("post_rst_2c", 10'h02C);
        check("final_count", evs.size(), 11);
        check("final_err", n_err, 2);
        check("final_ovf", n_ovf, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
